// File: rtl/fifo_pkg.sv
// Shared defaults, read-mode encodings and threshold sanity check for the
// parametrised synchronous FIFO family.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    localparam bit FWFT_STD  = 1'b0;
    localparam bit FWFT_FALL = 1'b1;

    // Thresholds are only meaningful when the almost-empty band sits strictly
    // below the almost-full band and neither exceeds the storage depth.
    function automatic bit th_ok(input int aempty_th, input int afull_th, input int depth);
        return (aempty_th < afull_th) && (afull_th <= depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags, optional
// first-word-fall-through read, synchronous flush and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AFULL_TH  = (1 << ADDR_W) - 2,
    parameter int AEMPTY_TH = 2,
    parameter bit FWFT      = FWFT_STD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

    if (!th_ok(AEMPTY_TH, AFULL_TH, 1 << ADDR_W)) begin : g_bad_th
        $error("sync_fifo_param: need AEMPTY_TH < AFULL_TH <= DEPTH");
    end

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Flags decode from registered count only, so enables never reach them.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (wr_en && !wr_acc);
        underflow_d = underflow_q | (rd_en && empty);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc && !flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    if (FWFT == FWFT_FALL) begin : g_fwft
        assign rd_data  = mem_rdata;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (flush) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem_rdata;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: standard-mode instance plus an FWFT instance.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       s_flush = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [7:0] s_wr_data = 8'h00;
    logic [7:0] s_rd_data;
    logic       s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic [3:0] s_count;

    logic       f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] f_wr_data = 8'h00;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [3:0] f_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1'b0)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_param #(
        .DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1'b1)
    ) u_fw (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if ({s_count, s_empty, s_full, s_aempty, s_afull} !== {4'd0, 4'b1010}) begin
            bad++; $display("FAIL reset_flags: got cnt=%0d e/f/ae/af=%b%b%b%b want cnt=0 1010",
                            s_count, s_empty, s_full, s_aempty, s_afull); end
        total++; if ({s_rd_valid, s_ovf, s_udf, s_rd_data} !== 11'd0) begin
            bad++; $display("FAIL reset_out: got v=%b o=%b u=%b d=%h want 0 0 0 00",
                            s_rd_valid, s_ovf, s_udf, s_rd_data); end
        total++; if ({f_empty, f_rd_valid, f_count} !== {2'b10, 4'd0}) begin
            bad++; $display("FAIL reset_fwft: got e=%b v=%b cnt=%0d want 1 0 0",
                            f_empty, f_rd_valid, f_count); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn reset done");
    endtask

    task automatic test_fill();
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            d = 8'(8'h11 * (i + 1));
            s_wr_en = 1'b1; s_wr_data = d;
            @(negedge clk);
            total++; if (s_count !== 4'(i + 1)) begin
                bad++; $display("FAIL fill_count: got %0d want %0d", s_count, i + 1); end
            total++; if (s_afull !== (i + 1 >= 6) || s_aempty !== (i + 1 <= 2) || s_empty !== 1'b0) begin
                bad++; $display("FAIL fill_flags: got af=%b ae=%b e=%b want af=%b ae=%b e=0",
                                s_afull, s_aempty, s_empty, (i + 1 >= 6), (i + 1 <= 2)); end
            $display("txn write %h count=%0d", d, s_count);
        end
        total++; if (s_full !== 1'b1) begin
            bad++; $display("FAIL full_after_8: got %b want 1", s_full); end
        s_wr_data = 8'h9F;
        @(negedge clk);
        s_wr_en = 1'b0;
        total++; if (s_ovf !== 1'b1 || s_count !== 4'd8) begin
            bad++; $display("FAIL overflow_9th: got ovf=%b cnt=%0d want 1 8", s_ovf, s_count); end
        $display("txn write 9F rejected ovf=%b", s_ovf);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [9] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h00};
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 8'h99;
        @(negedge clk);
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        total++; if (s_count !== 4'd8 || s_full !== 1'b1) begin
            bad++; $display("FAIL full_rw_count: got cnt=%0d full=%b want 8 1", s_count, s_full); end
        total++; if (s_rd_valid !== 1'b1 || s_rd_data !== 8'h11) begin
            bad++; $display("FAIL full_rw_data: got v=%b d=%h want 1 11", s_rd_valid, s_rd_data); end
        $display("txn rw-at-full read %h", s_rd_data);
        @(negedge clk);
        total++; if (s_rd_valid !== 1'b0 || s_rd_data !== 8'h11) begin
            bad++; $display("FAIL rd_valid_pulse: got v=%b d=%h want 0 11", s_rd_valid, s_rd_data); end
        for (int i = 0; i < 8; i++) begin
            s_rd_en = 1'b1;
            @(negedge clk);
            total++; if (s_rd_valid !== 1'b1 || s_rd_data !== exp_q[i]) begin
                bad++; $display("FAIL drain_%0d: got v=%b d=%h want 1 %h", i, s_rd_valid, s_rd_data, exp_q[i]); end
            $display("txn read %h", s_rd_data);
        end
        s_rd_en = 1'b0;
        @(negedge clk);
        total++; if (s_empty !== 1'b1 || s_count !== 4'd0 || s_udf !== 1'b0) begin
            bad++; $display("FAIL drained: got e=%b cnt=%0d u=%b want 1 0 0", s_empty, s_count, s_udf); end
    endtask

    task automatic test_empty_rw();
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 8'h5A;
        @(negedge clk);
        s_wr_en = 1'b0;
        total++; if (s_udf !== 1'b1 || s_count !== 4'd1 || s_rd_valid !== 1'b0) begin
            bad++; $display("FAIL empty_rw: got u=%b cnt=%0d v=%b want 1 1 0", s_udf, s_count, s_rd_valid); end
        @(negedge clk);
        s_rd_en = 1'b0;
        total++; if (s_rd_valid !== 1'b1 || s_rd_data !== 8'h5A || s_count !== 4'd0) begin
            bad++; $display("FAIL empty_rw_read: got v=%b d=%h cnt=%0d want 1 5a 0", s_rd_valid, s_rd_data, s_count); end
        $display("txn empty rw then read %h", s_rd_data);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            s_wr_en = 1'b1; s_wr_data = 8'(8'hC0 + i);
            @(negedge clk);
        end
        total++; if (s_count !== 4'd5 || s_ovf !== 1'b1) begin
            bad++; $display("FAIL pre_flush: got cnt=%0d ovf=%b want 5 1", s_count, s_ovf); end
        s_flush = 1'b1; s_wr_data = 8'hEE;
        @(negedge clk);
        s_flush = 1'b0; s_wr_en = 1'b0;
        total++; if (s_count !== 4'd0 || s_empty !== 1'b1 || s_ovf !== 1'b0 || s_udf !== 1'b0) begin
            bad++; $display("FAIL flush: got cnt=%0d e=%b o=%b u=%b want 0 1 0 0", s_count, s_empty, s_ovf, s_udf); end
        total++; if (s_rd_valid !== 1'b0 || s_rd_data !== 8'h00) begin
            bad++; $display("FAIL flush_rd: got v=%b d=%h want 0 00", s_rd_valid, s_rd_data); end
        s_rd_en = 1'b1;
        @(negedge clk);
        s_rd_en = 1'b0;
        total++; if (s_udf !== 1'b1 || s_rd_valid !== 1'b0 || s_count !== 4'd0) begin
            bad++; $display("FAIL flush_discard: got u=%b v=%b cnt=%0d want 1 0 0", s_udf, s_rd_valid, s_count); end
        $display("txn flush count=%0d", s_count);
    endtask

    task automatic test_fwft();
        f_wr_en = 1'b1; f_wr_data = 8'hA5;
        @(negedge clk);
        f_wr_en = 1'b0;
        total++; if (f_empty !== 1'b0 || f_rd_valid !== 1'b1 || f_rd_data !== 8'hA5) begin
            bad++; $display("FAIL fwft_show: got e=%b v=%b d=%h want 0 1 a5", f_empty, f_rd_valid, f_rd_data); end
        f_rd_en = 1'b1;
        @(negedge clk);
        f_rd_en = 1'b0;
        total++; if (f_empty !== 1'b1 || f_rd_valid !== 1'b0 || f_udf !== 1'b0) begin
            bad++; $display("FAIL fwft_pop: got e=%b v=%b u=%b want 1 0 0", f_empty, f_rd_valid, f_udf); end
        f_wr_en = 1'b1; f_wr_data = 8'hB1;
        @(negedge clk);
        f_wr_data = 8'hB2;
        @(negedge clk);
        f_wr_en = 1'b0; f_rd_en = 1'b1;
        total++; if (f_rd_data !== 8'hB1 || f_count !== 4'd2) begin
            bad++; $display("FAIL fwft_head: got d=%h cnt=%0d want b1 2", f_rd_data, f_count); end
        @(negedge clk);
        f_rd_en = 1'b0;
        total++; if (f_rd_data !== 8'hB2 || f_rd_valid !== 1'b1) begin
            bad++; $display("FAIL fwft_next: got d=%h v=%b want b2 1", f_rd_data, f_rd_valid); end
        $display("txn fwft head %h", f_rd_data);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            s_wr_en = 1'b1; s_wr_data = 8'(i + 1);
            @(negedge clk);
        end
        s_rd_en = 1'b1; s_wr_data = 8'h04;
        @(negedge clk);
        total++; if (s_count !== 4'd3 || s_rd_valid !== 1'b1 || s_rd_data !== 8'h01) begin
            bad++; $display("FAIL pre_areset: got cnt=%0d v=%b d=%h want 3 1 01", s_count, s_rd_valid, s_rd_data); end
        rst_n = 1'b0;
        #1;
        total++; if ({s_count, s_empty, s_full, s_aempty, s_afull} !== {4'd0, 4'b1010}) begin
            bad++; $display("FAIL areset_flags: got cnt=%0d e/f/ae/af=%b%b%b%b want 0 1010",
                            s_count, s_empty, s_full, s_aempty, s_afull); end
        total++; if ({s_rd_valid, s_ovf, s_udf, s_rd_data} !== 11'd0) begin
            bad++; $display("FAIL areset_out: got v=%b o=%b u=%b d=%h want 0 0 0 00",
                            s_rd_valid, s_ovf, s_udf, s_rd_data); end
        total++; if (f_empty !== 1'b1 || f_rd_valid !== 1'b0) begin
            bad++; $display("FAIL areset_fwft: got e=%b v=%b want 1 0", f_empty, f_rd_valid); end
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn async reset mid-burst");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_back_to_back();
        test_empty_rw();
        test_flush();
        test_fwft();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
